// File: rtl/pipe_sequencer.sv
// pipe_sequencer: run/drain/halt/single-step controller for a four-stage
// pipeline (PC/IFetch, IF/ID, ID/EX, EX/WB). Moore outputs decoded from
// the state register. Optional retired-instruction counter is built only
// when the macro PIPE_SEQ_RETIRE_CNT_EN is defined; otherwise retired_cnt
// is tied to zero.
module pipe_sequencer #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt_req,
    input  logic             halt_detect,
    input  logic             step_req,
    input  logic             wb_valid,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             flush_if_id,
    output logic             id_ex_en,
    output logic             ex_wb_en,
    output logic             busy,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired_cnt
);

    // A drain length below one cycle makes no sense; clamp it.
    localparam int DRAIN_EFF = (DRAIN_CYCLES < 1) ? 1 : DRAIN_CYCLES;
    localparam int DW        = (DRAIN_EFF < 2) ? 1 : $clog2(DRAIN_EFF + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_DRAIN  = 3'd2,
        S_HALTED = 3'd3,
        S_STEP   = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   drain_cnt_q, drain_cnt_d;

    // State and drain counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking (<=) so every flop samples
        // pre-edge values; blocking here would create order-dependent races.
        if (!rst) begin
            state_q     <= S_IDLE;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Next-state logic; DRAIN ignores every request until the pipe is empty.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal; a missing
        // branch would otherwise infer a latch.
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                if (halt_req || halt_detect) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = DW'(DRAIN_EFF);
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q <= DW'(1)) begin
                    state_d     = S_HALTED;
                    drain_cnt_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q - DW'(1);
                end
            end
            S_HALTED: begin
                if (start)         state_d = S_RUN;
                else if (step_req) state_d = S_STEP;
            end
            S_STEP: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d     = S_IDLE;
                drain_cnt_d = '0;
            end
        endcase
    end

    // Moore output decode; pc_en and flush_if_id are never both high.
    always_comb begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        flush_if_id = 1'b0;
        id_ex_en    = 1'b0;
        ex_wb_en    = 1'b0;
        busy        = 1'b0;
        halted      = 1'b0;
        case (state_q)
            S_RUN, S_STEP: begin
                pc_en    = 1'b1;
                if_id_en = 1'b1;
                id_ex_en = 1'b1;
                ex_wb_en = 1'b1;
                busy     = 1'b1;
            end
            S_DRAIN: begin
                if_id_en    = 1'b1;
                flush_if_id = 1'b1;
                id_ex_en    = 1'b1;
                ex_wb_en    = 1'b1;
                busy        = 1'b1;
            end
            S_HALTED: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign state = state_q;

`ifdef PIPE_SEQ_RETIRE_CNT_EN
    logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;

    // Saturating count of real instructions leaving EX/WB.
    always_comb begin
        retired_cnt_d = retired_cnt_q;
        if (ex_wb_en && wb_valid && (retired_cnt_q != {CNT_W{1'b1}}))
            retired_cnt_d = retired_cnt_q + CNT_W'(1);
    end

    // Retired counter register.
    always_ff @(posedge clk) begin
        if (!rst) retired_cnt_q <= '0;
        else      retired_cnt_q <= retired_cnt_d;
    end

    assign retired_cnt = retired_cnt_q;
`else
    // Counter compiled out: port kept, constant zero, wb_valid unused.
    logic unused_wb_valid;
    assign unused_wb_valid = wb_valid;
    assign retired_cnt     = '0;
`endif

endmodule
